// File: rtl/vga_if.sv
// Raster-scan bundle from the timing generator to the pixel-colour stages.
// Coordinates, sync/blank flags, strobes and frame counter, all cycle-aligned.
interface vga_if #(
    parameter int FC_W = 8
);
    logic [9:0]      DrawX;
    logic [9:0]      DrawY;
    logic            hs;
    logic            vs;
    logic            blank;
    logic            line_start;
    logic            frame_start;
    logic [FC_W-1:0] frame_count;

    modport master (
        output DrawX, DrawY, hs, vs, blank, line_start, frame_start, frame_count
    );

    modport slave (
        input DrawX, DrawY, hs, vs, blank, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster generator: pixel coordinates plus registered sync,
// blank, line/frame strobes and a frame counter, all describing the same pixel.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int FC_W      = 8
) (
    input  logic  vga_clk,
    input  logic  reset_n,
    vga_if.master vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    function automatic logic in_window(input logic [9:0] v,
                                       input logic [9:0] lo,
                                       input logic [9:0] hi);
        return (v >= lo) && (v < hi);
    endfunction

    logic [9:0]      x_r, y_r;
    logic            hs_r, vs_r, blank_r, line_start_r, frame_start_r;
    logic [FC_W-1:0] fc_r;

    logic [9:0]      x_nxt_s, y_nxt_s;
    logic            hs_nxt_s, vs_nxt_s, blank_nxt_s, ls_nxt_s, fs_nxt_s;
    logic [FC_W-1:0] fc_nxt_s;

    // Next scan position and the flags that will describe it.
    always_comb begin
        x_nxt_s = x_r;
        y_nxt_s = y_r;
        if (x_r == H_LAST) begin
            x_nxt_s = 10'd0;
            if (y_r == V_LAST) begin
                y_nxt_s = 10'd0;
            end else begin
                y_nxt_s = y_r + 10'd1;
            end
        end else begin
            x_nxt_s = x_r + 10'd1;
        end

        blank_nxt_s = (x_nxt_s < H_VIS) && (y_nxt_s < V_VIS);
        hs_nxt_s    = !in_window(x_nxt_s, HS_START, HS_END);
        vs_nxt_s    = !in_window(y_nxt_s, VS_START, VS_END);
        ls_nxt_s    = (x_nxt_s == 10'd0);
        fs_nxt_s    = (x_nxt_s == 10'd0) && (y_nxt_s == 10'd0);

        // Count moves with the strobe so the (0,0) cycle already shows the new frame.
        if (fs_nxt_s) begin
            fc_nxt_s = fc_r + FC_W'(1);
        end else begin
            fc_nxt_s = fc_r;
        end
    end

    // Output registers; reset parks the scan on the last back-porch pixel.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            x_r           <= H_LAST;
            y_r           <= V_LAST;
            hs_r          <= 1'b1;
            vs_r          <= 1'b1;
            blank_r       <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            fc_r          <= '0;
        end else begin
            x_r           <= x_nxt_s;
            y_r           <= y_nxt_s;
            hs_r          <= hs_nxt_s;
            vs_r          <= vs_nxt_s;
            blank_r       <= blank_nxt_s;
            line_start_r  <= ls_nxt_s;
            frame_start_r <= fs_nxt_s;
            fc_r          <= fc_nxt_s;
        end
    end

    assign vga.DrawX       = x_r;
    assign vga.DrawY       = y_r;
    assign vga.hs          = hs_r;
    assign vga.vs          = vs_r;
    assign vga.blank       = blank_r;
    assign vga.line_start  = line_start_r;
    assign vga.frame_start = frame_start_r;
    assign vga.frame_count = fc_r;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: full-size and shrunken instances on one clock,
// checked each cycle against an arithmetic raster model plus directed tables.
module tb_vga_timing_gen;
    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       blank;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    typedef struct {
        logic rb;
        int   n;
        obs_t exp;
    } vec_t;

    logic vga_clk = 1'b0;
    logic big_rst_n = 1'b0;
    logic sml_rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    bit   b_in = 1'b1, s_in = 1'b1;
    int   b_t = 0, s_t = 0;

    always #5 vga_clk = ~vga_clk;

    vga_if #(.FC_W(8)) bif ();
    vga_if #(.FC_W(8)) sif ();

    vga_timing_gen #(.FC_W(8)) u_big (
        .vga_clk (vga_clk),
        .reset_n (big_rst_n),
        .vga     (bif)
    );

    vga_timing_gen #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .FC_W(8)
    ) u_sml (
        .vga_clk (vga_clk),
        .reset_n (sml_rst_n),
        .vga     (sif)
    );

    obs_t big_obs, sml_obs;
    assign big_obs = {bif.DrawX, bif.DrawY, bif.hs, bif.vs, bif.blank,
                      bif.line_start, bif.frame_start, bif.frame_count};
    assign sml_obs = {sif.DrawX, sif.DrawY, sif.hs, sif.vs, sif.blank,
                      sif.line_start, sif.frame_start, sif.frame_count};

    function automatic obs_t mk(int x, int y, bit hs, bit vs, bit bl,
                                bit ls, bit fs, int fc);
        obs_t o;
        o.x = 10'(x); o.y = 10'(y); o.hs = hs; o.vs = vs; o.blank = bl;
        o.ls = ls; o.fs = fs; o.fc = 8'(fc);
        return o;
    endfunction

    // Raster position is simply elapsed cycles since reset release.
    function automatic obs_t ref_out(bit in_rst, int t, int hv, int hf, int hsy,
                                     int hb, int vv, int vf, int vsy, int vb);
        int ht = hv + hf + hsy + hb;
        int vt = vv + vf + vsy + vb;
        int x, y, f;
        if (in_rst) return mk(ht - 1, vt - 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        x = t % ht;
        y = (t / ht) % vt;
        f = (t / (ht * vt)) + 1;
        return mk(x, y,
                  !(x >= hv + hf && x < hv + hf + hsy),
                  !(y >= vv + vf && y < vv + vf + vsy),
                  (x < hv) && (y < vv),
                  x == 0, (x == 0) && (y == 0), f % 256);
    endfunction

    task automatic chk_obs(string nm, obs_t a, obs_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got x=%0d y=%0d hs=%b vs=%b blank=%b ls=%b fs=%b fc=%0d, expected x=%0d y=%0d hs=%b vs=%b blank=%b ls=%b fs=%b fc=%0d",
                     nm, a.x, a.y, a.hs, a.vs, a.blank, a.ls, a.fs, a.fc,
                     e.x, e.y, e.hs, e.vs, e.blank, e.ls, e.fs, e.fc);
        end
    endtask

    task automatic chk_int(string nm, int a, int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, a, e);
        end
    endtask

    // One clock edge for both instances, then model update and check at negedge.
    task automatic tick(input logic rb, input logic rs);
        big_rst_n = rb;
        sml_rst_n = rs;
        @(posedge vga_clk);
        if (!rb) begin b_in = 1'b1; b_t = 0; end
        else if (b_in) begin b_in = 1'b0; b_t = 0; end
        else b_t++;
        if (!rs) begin s_in = 1'b1; s_t = 0; end
        else if (s_in) begin s_in = 1'b0; s_t = 0; end
        else s_t++;
        @(negedge vga_clk);
        chk_obs("big_model", big_obs, ref_out(b_in, b_t, 640, 16, 96, 48, 480, 10, 2, 33));
        chk_obs("sml_model", sml_obs, ref_out(s_in, s_t, 8, 2, 2, 2, 4, 1, 1, 1));
    endtask

    vec_t vecs[13];

    initial begin
        int cnt, hs_low, vs_low;

        vecs[0]  = '{1'b0, 5,   mk(799, 524, 1, 1, 0, 0, 0, 0)};
        vecs[1]  = '{1'b1, 1,   mk(0,   0,   1, 1, 1, 1, 1, 1)};
        vecs[2]  = '{1'b1, 639, mk(639, 0,   1, 1, 1, 0, 0, 1)};
        vecs[3]  = '{1'b1, 1,   mk(640, 0,   1, 1, 0, 0, 0, 1)};
        vecs[4]  = '{1'b1, 15,  mk(655, 0,   1, 1, 0, 0, 0, 1)};
        vecs[5]  = '{1'b1, 1,   mk(656, 0,   0, 1, 0, 0, 0, 1)};
        vecs[6]  = '{1'b1, 95,  mk(751, 0,   0, 1, 0, 0, 0, 1)};
        vecs[7]  = '{1'b1, 1,   mk(752, 0,   1, 1, 0, 0, 0, 1)};
        vecs[8]  = '{1'b1, 47,  mk(799, 0,   1, 1, 0, 0, 0, 1)};
        vecs[9]  = '{1'b1, 1,   mk(0,   1,   1, 1, 1, 1, 0, 1)};
        vecs[10] = '{1'b1, 300, mk(300, 1,   1, 1, 1, 0, 0, 1)};
        vecs[11] = '{1'b0, 1,   mk(799, 524, 1, 1, 0, 0, 0, 0)};
        vecs[12] = '{1'b1, 1,   mk(0,   0,   1, 1, 1, 1, 1, 1)};

        @(negedge vga_clk);
        for (int i = 0; i < 13; i++) begin
            for (int k = 0; k < vecs[i].n; k++) tick(vecs[i].rb, 1'b0);
            chk_obs($sformatf("big_vec%0d", i), big_obs, vecs[i].exp);
        end

        // Small instance: release, then walk 255 more frames through the counter wrap.
        tick(1'b1, 1'b1);
        chk_obs("sml_first", sml_obs, mk(0, 0, 1, 1, 1, 1, 1, 1));
        for (int f = 2; f <= 256; f++) begin
            cnt    = 0;
            hs_low = sml_obs.hs ? 0 : 1;
            vs_low = sml_obs.vs ? 0 : 1;
            while (cnt < 200) begin
                tick(1'b1, 1'b1);
                cnt++;
                if (sml_obs.fs) break;
                if (!sml_obs.hs) hs_low++;
                if (!sml_obs.vs) vs_low++;
            end
            chk_int("sml_frame_period", cnt, 98);
            chk_int("sml_frame_count", int'(sml_obs.fc), f % 256);
            chk_int("sml_hs_low_cycles", hs_low, 14);
            chk_int("sml_vs_low_cycles", vs_low, 14);
        end

        // One-edge reset in mid-frame on the small instance.
        cnt = 0;
        while (!(sml_obs.x == 10'd3 && sml_obs.y == 10'd2) && cnt < 200) begin
            tick(1'b1, 1'b1);
            cnt++;
        end
        chk_int("sml_reach_3_2", int'(sml_obs.x) * 1000 + int'(sml_obs.y), 3002);
        tick(1'b1, 1'b0);
        chk_obs("sml_mid_reset", sml_obs, mk(13, 6, 1, 1, 0, 0, 0, 0));
        tick(1'b1, 1'b1);
        chk_obs("sml_restart", sml_obs, mk(0, 0, 1, 1, 1, 1, 1, 1));

        // Random reset pulses on both instances, model-checked every cycle.
        for (int k = 0; k < 3000; k++) begin
            tick(logic'($urandom_range(0, 199) != 0), logic'($urandom_range(0, 149) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
